mac_port_arbiter: RTL and testbench
===================================

Name: mac_port_arbiter

Overview:
- Arbitrates the shared MAC pin pair (MacTx/MacRx) between the CLK UART core and the CLK I2C core.
- Only one core owns the pins at a time.
- Every ownership change passes through a tristated guard interval so the two cores never contend on the pins.
- Sits between the block-design cores and the top-level tristate buffers; drives the Clk_RxSda/Clk_TxScl data and tristate-enable nets.

Parameters:
- GuardCycles_Gen, 50, number of cycles both pins stay tristated between owners; must be >= 1.
- HoldTimeout_Gen, 0, max cycles an owner holds the pins while the other requester waits; 0 disables preemption.

Ports:
- Mhz50Clk_Clk  in  1  system clock, 50 MHz
- Mhz50RstN_Rst  in  1  reset, asynchronous, active-high
- UartReq_ValIn  in  1  UART requests the pins (level)
- I2cReq_ValIn  in  1  I2C requests the pins (level)
- UartGnt_ValOut  out  1  UART owns the pins
- I2cGnt_ValOut  out  1  I2C owns the pins
- Preempt_EvtOut  out  1  one-cycle pulse when an owner is revoked by timeout
- UartTx_DatIn  in  1  UART transmit data
- UartRx_DatOut  out  1  UART receive data
- I2cScl_DatIn / I2cSclT_EnaIn  in  1/1  I2C SCL output value / tristate (1 = Z)
- I2cSda_DatIn / I2cSdaT_EnaIn  in  1/1  I2C SDA output value / tristate
- I2cScl_DatOut / I2cSda_DatOut  out  1/1  SCL/SDA input values returned to the I2C core
- Clk_TxScl_DatIn / Clk_RxSda_DatIn  in  1/1  pin input values
- Clk_TxScl_DatOut / Clk_TxSclT_EnaOut  out  1/1  Tx/SCL pin drive value / tristate (1 = Z)
- Clk_RxSda_DatOut / Clk_RxSdaT_EnaOut  out  1/1  Rx/SDA pin drive value / tristate

Behaviour:
- State register with states IDLE, GUARD, UART, I2C.
  - Registers: GuardCnt (32 bit), HoldCnt (32 bit), Target (UART/I2C), LastOwner (reset value I2C, so UART wins the first tie).
- Reset, asynchronous:
  - state IDLE, counters 0, both grants 0, Preempt_EvtOut 0.
  - Both T outputs 1, both pin data outputs 1.
  - UartRx_DatOut, I2cScl_DatOut and I2cSda_DatOut all 1.
- Pin mux is combinational from the registered state (zero-cycle data path):
  - UART state: Tx pin T=0, O=UartTx_DatIn; Rx pin T=1; UartRx_DatOut=Clk_RxSda_DatIn.
  - I2C state: Tx pin T=I2cSclT_EnaIn, O=I2cScl_DatIn; Rx pin T=I2cSdaT_EnaIn, O=I2cSda_DatIn; I2cScl/Sda_DatOut = pin inputs.
  - IDLE/GUARD: both T=1, O=1.
  - A non-owner core always sees its inputs at 1 (idle line).
- Grants are decoded from the state register: UartGnt_ValOut=1 iff state UART; I2cGnt_ValOut=1 iff state I2C. They are never both 1.
- IDLE:
  - Any request -> GUARD, GuardCnt=0, Target=requester.
  - If both request, Target = requester != LastOwner.
- GUARD:
  - GuardCnt increments each cycle.
  - When GuardCnt == GuardCycles_Gen-1: go to Target if its request is still high. Set LastOwner=Target and HoldCnt=0.
  - If Target's request is low at that point: go to GUARD for the other requester if it is requesting, else IDLE.
  - Grant latency: request high at edge k -> grant high after edge k+1+GuardCycles_Gen.
- Owner state (UART or I2C):
  - Owner request low -> GUARD with Target=other if the other is requesting, else -> IDLE (pins Z from the next cycle).
  - HoldCnt increments while the other requester is high; it clears when the other requester is low.
  - If HoldTimeout_Gen != 0 and HoldCnt == HoldTimeout_Gen-1 with the other requester high: -> GUARD, Target=other, Preempt_EvtOut=1 for one cycle.
  - A preempted owner keeping its request high is re-granted after the new owner releases (normal alternation).
- A request drop and the timeout in the same cycle: the release wins and no preempt pulse is generated.
- Counters saturate and never wrap.

Test Plan:
- Reset mid-grant: hold reset while in UART -> grants 0, T outputs 1, data outputs 1, state IDLE on release; a new request is granted after 1+GuardCycles_Gen cycles.
- UART only, Guard=50: UartReq high at cycle 10 -> UartGnt high at cycle 61; Tx pin follows UartTx with T=0; Rx T=1; UartRx_DatOut mirrors Clk_RxSda_DatIn; I2cScl/Sda_DatOut=1.
- Tie after reset: both requests high together -> UART granted first. UART drops -> 50 Z cycles -> I2cGnt=1 and pins follow the I2C T/O.
- Handover guard check: during the GUARD window both T outputs are 1 every cycle and neither grant is high.
- Target withdraws during GUARD: I2cReq drops at guard cycle 20 -> state IDLE at guard end and no grant is issued.
- Preemption with HoldTimeout=1000: UART granted, I2cReq high continuously -> Preempt_EvtOut pulses exactly once 1000 cycles after I2cReq rose. UartGnt falls; I2cGnt rises after a further 50 cycles.

Source files
------------

// File: rtl/mac_port_arbiter_if.sv
// Signal bundle between the MAC pin arbiter, the UART/I2C cores and the pin tristate buffers.
// The arbiter uses the slave view; the cores and pad ring together form the master view.
interface mac_port_arbiter_if;
   logic UartReq_ValIn;
   logic I2cReq_ValIn;
   logic UartGnt_ValOut;
   logic I2cGnt_ValOut;
   logic Preempt_EvtOut;

   logic UartTx_DatIn;
   logic UartRx_DatOut;

   logic I2cScl_DatIn;
   logic I2cSclT_EnaIn;
   logic I2cSda_DatIn;
   logic I2cSdaT_EnaIn;
   logic I2cScl_DatOut;
   logic I2cSda_DatOut;

   logic Clk_TxScl_DatIn;
   logic Clk_RxSda_DatIn;
   logic Clk_TxScl_DatOut;
   logic Clk_TxSclT_EnaOut;
   logic Clk_RxSda_DatOut;
   logic Clk_RxSdaT_EnaOut;

   modport slave (
      input  UartReq_ValIn, I2cReq_ValIn, UartTx_DatIn,
      input  I2cScl_DatIn, I2cSclT_EnaIn, I2cSda_DatIn, I2cSdaT_EnaIn,
      input  Clk_TxScl_DatIn, Clk_RxSda_DatIn,
      output UartGnt_ValOut, I2cGnt_ValOut, Preempt_EvtOut,
      output UartRx_DatOut, I2cScl_DatOut, I2cSda_DatOut,
      output Clk_TxScl_DatOut, Clk_TxSclT_EnaOut, Clk_RxSda_DatOut, Clk_RxSdaT_EnaOut
   );

   modport master (
      output UartReq_ValIn, I2cReq_ValIn, UartTx_DatIn,
      output I2cScl_DatIn, I2cSclT_EnaIn, I2cSda_DatIn, I2cSdaT_EnaIn,
      output Clk_TxScl_DatIn, Clk_RxSda_DatIn,
      input  UartGnt_ValOut, I2cGnt_ValOut, Preempt_EvtOut,
      input  UartRx_DatOut, I2cScl_DatOut, I2cSda_DatOut,
      input  Clk_TxScl_DatOut, Clk_TxSclT_EnaOut, Clk_RxSda_DatOut, Clk_RxSdaT_EnaOut
   );
endinterface

// File: rtl/mac_port_arbiter.sv
// Shares the MacTx/MacRx pin pair between the UART and I2C cores, with a tristated
// guard interval on every ownership change and optional timeout-based preemption.
module mac_port_arbiter #(
   parameter int unsigned GuardCycles_Gen = 50,
   parameter int unsigned HoldTimeout_Gen = 0
) (
   input  logic              Mhz50Clk_Clk,
   input  logic              Mhz50RstN_Rst,
   mac_port_arbiter_if.slave bus_if
);
   typedef enum logic [1:0] {IDLE, GUARD, UART, I2C} state_e;
   typedef enum logic {OWN_UART, OWN_I2C} owner_e;

   localparam logic [31:0] GuardLast = 32'(GuardCycles_Gen - 1);
   localparam logic [31:0] HoldLast  = 32'(HoldTimeout_Gen - 1);
   localparam logic [31:0] CntMax    = '1;

   state_e      state_q, state_d;
   logic [31:0] guard_cnt_q, guard_cnt_d;
   logic [31:0] hold_cnt_q, hold_cnt_d;
   owner_e      target_q, target_d;
   owner_e      last_owner_q, last_owner_d;
   logic        preempt_q, preempt_d;

   logic   uart_req, i2c_req;
   logic   target_req, alt_req, own_req, waiting_req;
   owner_e alt_target, waiting_owner;

   assign uart_req      = bus_if.UartReq_ValIn;
   assign i2c_req       = bus_if.I2cReq_ValIn;
   assign target_req    = (target_q == OWN_UART) ? uart_req : i2c_req;
   assign alt_req       = (target_q == OWN_UART) ? i2c_req : uart_req;
   assign alt_target    = (target_q == OWN_UART) ? OWN_I2C : OWN_UART;
   assign own_req       = (state_q == UART) ? uart_req : i2c_req;
   assign waiting_req   = (state_q == UART) ? i2c_req : uart_req;
   assign waiting_owner = (state_q == UART) ? OWN_I2C : OWN_UART;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Mhz50Clk_Clk or posedge Mhz50RstN_Rst) begin
      if (Mhz50RstN_Rst) begin
         state_q      <= IDLE;
         guard_cnt_q  <= '0;
         hold_cnt_q   <= '0;
         target_q     <= OWN_UART;
         last_owner_q <= OWN_I2C;
         preempt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         guard_cnt_q  <= guard_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         target_q     <= target_d;
         last_owner_q <= last_owner_d;
         preempt_q    <= preempt_d;
      end
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      guard_cnt_d  = guard_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      target_d     = target_q;
      last_owner_d = last_owner_q;
      preempt_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (uart_req || i2c_req) begin
               state_d     = GUARD;
               guard_cnt_d = '0;
               if (uart_req && i2c_req)
                  target_d = (last_owner_q == OWN_UART) ? OWN_I2C : OWN_UART;
               else
                  target_d = uart_req ? OWN_UART : OWN_I2C;
            end
         end

         GUARD: begin
            if (guard_cnt_q != CntMax)
               guard_cnt_d = guard_cnt_q + 32'd1;
            if (guard_cnt_q == GuardLast) begin
               if (target_req) begin
                  state_d      = (target_q == OWN_UART) ? UART : I2C;
                  last_owner_d = target_q;
                  hold_cnt_d   = '0;
               end else if (alt_req) begin
                  // Target withdrew: restart the full guard for the other core.
                  guard_cnt_d = '0;
                  target_d    = alt_target;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         UART, I2C: begin
            if (!own_req) begin
               // A release takes priority over a coincident timeout, so no pulse here.
               if (waiting_req) begin
                  state_d     = GUARD;
                  guard_cnt_d = '0;
                  target_d    = waiting_owner;
               end else begin
                  state_d = IDLE;
               end
            end else if (waiting_req) begin
               if ((HoldTimeout_Gen != 0) && (hold_cnt_q == HoldLast)) begin
                  state_d     = GUARD;
                  guard_cnt_d = '0;
                  target_d    = waiting_owner;
                  preempt_d   = 1'b1;
               end else if (hold_cnt_q != CntMax) begin
                  hold_cnt_d = hold_cnt_q + 32'd1;
               end
            end else begin
               hold_cnt_d = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus_if.UartGnt_ValOut = (state_q == UART);
   assign bus_if.I2cGnt_ValOut  = (state_q == I2C);
   assign bus_if.Preempt_EvtOut = preempt_q;

   // Zero-latency pin mux; a core that does not own the pins sees an idle-high line.
   always_comb begin
      bus_if.Clk_TxScl_DatOut  = 1'b1;
      bus_if.Clk_TxSclT_EnaOut = 1'b1;
      bus_if.Clk_RxSda_DatOut  = 1'b1;
      bus_if.Clk_RxSdaT_EnaOut = 1'b1;
      bus_if.UartRx_DatOut     = 1'b1;
      bus_if.I2cScl_DatOut     = 1'b1;
      bus_if.I2cSda_DatOut     = 1'b1;

      case (state_q)
         UART: begin
            bus_if.Clk_TxScl_DatOut  = bus_if.UartTx_DatIn;
            bus_if.Clk_TxSclT_EnaOut = 1'b0;
            bus_if.UartRx_DatOut     = bus_if.Clk_RxSda_DatIn;
         end
         I2C: begin
            bus_if.Clk_TxScl_DatOut  = bus_if.I2cScl_DatIn;
            bus_if.Clk_TxSclT_EnaOut = bus_if.I2cSclT_EnaIn;
            bus_if.Clk_RxSda_DatOut  = bus_if.I2cSda_DatIn;
            bus_if.Clk_RxSdaT_EnaOut = bus_if.I2cSdaT_EnaIn;
            bus_if.I2cScl_DatOut     = bus_if.Clk_TxScl_DatIn;
            bus_if.I2cSda_DatOut     = bus_if.Clk_RxSda_DatIn;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mac_port_arbiter.sv
// Randomized and directed bench for mac_port_arbiter; a per-cycle reference model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_mac_port_arbiter;
   localparam int G  = 50;
   localparam int HT = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mac_port_arbiter_if bif ();

   mac_port_arbiter #(
      .GuardCycles_Gen(G),
      .HoldTimeout_Gen(HT)
   ) dut (
      .Mhz50Clk_Clk (clk),
      .Mhz50RstN_Rst(rst),
      .bus_if       (bif)
   );

   int checks   = 0;
   int failures = 0;

   // Output vector order: UartGnt I2cGnt Preempt TxO TxT RxO RxT UartRx I2cScl I2cSda
   logic [9:0] sb [$];

   // Reference model: owner 0 = nobody, 1 = UART, 2 = I2C.
   int m_owner, m_guard_left, m_pending, m_last, m_wait;
   bit m_preempt;
   int preempt_seen = 0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit want(input int who, input bit u, input bit i);
      return (who == 1) ? u : i;
   endfunction

   task automatic model_reset();
      m_owner      = 0;
      m_guard_left = 0;
      m_pending    = 0;
      m_last       = 2;
      m_wait       = 0;
      m_preempt    = 1'b0;
   endtask

   task automatic model_step(input bit u, input bit i);
      m_preempt = 1'b0;
      if (m_guard_left > 0) begin
         m_guard_left--;
         if (m_guard_left == 0) begin
            if (want(m_pending, u, i)) begin
               m_owner = m_pending;
               m_last  = m_pending;
               m_wait  = 0;
            end else if (want(3 - m_pending, u, i)) begin
               m_pending    = 3 - m_pending;
               m_guard_left = G;
            end
         end
      end else if (m_owner == 0) begin
         if (u && i) begin
            m_pending    = 3 - m_last;
            m_guard_left = G;
         end else if (u || i) begin
            m_pending    = u ? 1 : 2;
            m_guard_left = G;
         end
      end else if (!want(m_owner, u, i)) begin
         if (want(3 - m_owner, u, i)) begin
            m_pending    = 3 - m_owner;
            m_guard_left = G;
         end
         m_owner = 0;
      end else if (want(3 - m_owner, u, i)) begin
         m_wait++;
         if (HT != 0 && m_wait >= HT) begin
            m_pending    = 3 - m_owner;
            m_guard_left = G;
            m_owner      = 0;
            m_preempt    = 1'b1;
         end
      end else begin
         m_wait = 0;
      end
   endtask

   function automatic logic [9:0] expect_outs();
      logic tx_o, tx_t, rx_o, rx_t, urx, scl, sda;
      tx_o = 1'b1; tx_t = 1'b1; rx_o = 1'b1; rx_t = 1'b1;
      urx  = 1'b1; scl  = 1'b1; sda  = 1'b1;
      if (m_owner == 1) begin
         tx_o = bif.UartTx_DatIn;
         tx_t = 1'b0;
         urx  = bif.Clk_RxSda_DatIn;
      end else if (m_owner == 2) begin
         tx_o = bif.I2cScl_DatIn;
         tx_t = bif.I2cSclT_EnaIn;
         rx_o = bif.I2cSda_DatIn;
         rx_t = bif.I2cSdaT_EnaIn;
         scl  = bif.Clk_TxScl_DatIn;
         sda  = bif.Clk_RxSda_DatIn;
      end
      return {m_owner == 1, m_owner == 2, m_preempt, tx_o, tx_t, rx_o, rx_t, urx, scl, sda};
   endfunction

   function automatic logic [9:0] actual_outs();
      return {bif.UartGnt_ValOut, bif.I2cGnt_ValOut, bif.Preempt_EvtOut,
              bif.Clk_TxScl_DatOut, bif.Clk_TxSclT_EnaOut, bif.Clk_RxSda_DatOut,
              bif.Clk_RxSdaT_EnaOut, bif.UartRx_DatOut, bif.I2cScl_DatOut, bif.I2cSda_DatOut};
   endfunction

   task automatic randomize_data();
      bif.UartTx_DatIn    = 1'($urandom());
      bif.I2cScl_DatIn    = 1'($urandom());
      bif.I2cSclT_EnaIn   = 1'($urandom());
      bif.I2cSda_DatIn    = 1'($urandom());
      bif.I2cSdaT_EnaIn   = 1'($urandom());
      bif.Clk_TxScl_DatIn = 1'($urandom());
      bif.Clk_RxSda_DatIn = 1'($urandom());
   endtask

   // One clock: advance the model with the inputs seen at the edge, then drive new data.
   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(bif.UartReq_ValIn, bif.I2cReq_ValIn);
      #1;
      randomize_data();
      if (bif.Preempt_EvtOut === 1'b1) preempt_seen++;
      sb.push_back(expect_outs());
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      sb.delete();
      model_reset();
      #1;
      check(actual_outs() == expect_outs(), "async_reset_outputs",
            int'(actual_outs()), int'(expect_outs()));
      sb.push_back(expect_outs());
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic ticks_until_gnt(input bit uart_side, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (((uart_side ? bif.UartGnt_ValOut : bif.I2cGnt_ValOut) !== 1'b1) && n < limit);
   endtask

   task automatic ticks_until_preempt(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bif.Preempt_EvtOut !== 1'b1 && n < limit);
   endtask

   initial begin : monitor
      logic [9:0] exp_v;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            check(actual_outs() == exp_v, "cycle_outputs", int'(actual_outs()), int'(exp_v));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      int n;
      int grants;
      bif.UartReq_ValIn = 1'b0;
      bif.I2cReq_ValIn  = 1'b0;
      randomize_data();
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();

      // UART alone: grant after 1+G cycles.
      bif.UartReq_ValIn = 1'b1;
      ticks_until_gnt(1'b1, G + 20, n);
      check(n == G + 1, "uart_only_latency", n, G + 1);
      check(bif.I2cGnt_ValOut == 1'b0, "uart_only_i2c_gnt", int'(bif.I2cGnt_ValOut), 0);
      repeat (10) tick();

      // Reset while UART owns the pins, then regrant.
      do_reset(4);
      ticks_until_gnt(1'b1, G + 20, n);
      check(n == G + 1, "regrant_after_reset", n, G + 1);

      // Tie after reset: UART first, then handover to I2C.
      bif.UartReq_ValIn = 1'b0;
      repeat (3) tick();
      do_reset(2);
      bif.UartReq_ValIn = 1'b1;
      bif.I2cReq_ValIn  = 1'b1;
      ticks_until_gnt(1'b1, G + 20, n);
      check(n == G + 1, "tie_uart_first", n, G + 1);
      check(bif.I2cGnt_ValOut == 1'b0, "tie_i2c_waits", int'(bif.I2cGnt_ValOut), 0);
      bif.UartReq_ValIn = 1'b0;
      ticks_until_gnt(1'b0, G + 20, n);
      check(n == G + 1, "handover_to_i2c", n, G + 1);
      bif.I2cReq_ValIn = 1'b0;
      repeat (5) tick();

      // Target withdraws mid-guard: no grant at all.
      grants = 0;
      bif.I2cReq_ValIn = 1'b1;
      repeat (21) begin
         tick();
         if (bif.UartGnt_ValOut || bif.I2cGnt_ValOut) grants++;
      end
      bif.I2cReq_ValIn = 1'b0;
      repeat (G + 10) begin
         tick();
         if (bif.UartGnt_ValOut || bif.I2cGnt_ValOut) grants++;
      end
      check(grants == 0, "withdraw_no_grant", grants, 0);

      // Preemption after HT cycles of waiting, then alternation back to UART.
      bif.UartReq_ValIn = 1'b1;
      ticks_until_gnt(1'b1, G + 20, n);
      check(n == G + 1, "preempt_setup_grant", n, G + 1);
      repeat (5) tick();
      preempt_seen = 0;
      bif.I2cReq_ValIn = 1'b1;
      ticks_until_preempt(HT + 20, n);
      check(n == HT, "preempt_delay", n, HT);
      check(bif.UartGnt_ValOut == 1'b0, "preempt_uart_revoked", int'(bif.UartGnt_ValOut), 0);
      ticks_until_gnt(1'b0, G + 20, n);
      check(n == G, "preempt_i2c_grant", n, G);
      check(preempt_seen == 1, "preempt_single_pulse", preempt_seen, 1);
      bif.I2cReq_ValIn = 1'b0;
      ticks_until_gnt(1'b1, G + 20, n);
      check(n == G + 1, "preempted_regrant", n, G + 1);
      bif.UartReq_ValIn = 1'b0;
      repeat (5) tick();

      // Random traffic: fast toggling, then slow toggling so timeouts occur.
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(99, 0) == 0) bif.UartReq_ValIn = ~bif.UartReq_ValIn;
         if ($urandom_range(99, 0) == 0) bif.I2cReq_ValIn  = ~bif.I2cReq_ValIn;
         if ($urandom_range(4999, 0) == 0) do_reset(2);
         tick();
      end
      for (int c = 0; c < 12000; c++) begin
         if ($urandom_range(1499, 0) == 0) bif.UartReq_ValIn = ~bif.UartReq_ValIn;
         if ($urandom_range(1499, 0) == 0) bif.I2cReq_ValIn  = ~bif.I2cReq_ValIn;
         tick();
      end

      bif.UartReq_ValIn = 1'b0;
      bif.I2cReq_ValIn  = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
